gpio_scan_ctrl: RTL

- Serial-to-parallel front end between the GPIO test pins and the SRAM macro mux in the test chip.
- Shifts in a 112-bit command packet and launches one SRAM access per global_csb strobe on both ports.
- Captures the read data and loads it back into the chain so it can be scanned out on gpio_out.
- Sits directly upstream of the SRAM select/mux logic; its outputs feed the selected macro's port 0 and port 1.

---
 rtl/gpio_scan_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gpio_scan_ctrl.sv
// GPIO scan front end: shifts a 112-bit command packet, launches one dual-port SRAM access per strobe,
// captures read data and reloads it into the chain. Optional parity check enabled by GPIO_SCAN_PARITY_EN.
module gpio_scan_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int WMASK_WIDTH = 4,
    localparam int CHAIN_WIDTH = SEL_WIDTH + 2*(ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_en,
    input  logic                   scan_in,
    output logic                   scan_out,
    input  logic                   sram_load,
    input  logic                   global_csb,
    output logic [SEL_WIDTH-1:0]   sram_sel,
    output logic                   csb0,
    output logic                   web0,
    output logic [ADDR_WIDTH-1:0]  addr0,
    output logic [DATA_WIDTH-1:0]  din0,
    output logic [WMASK_WIDTH-1:0] wmask0,
    output logic                   csb1,
    output logic                   web1,
    output logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  din1,
    output logic [WMASK_WIDTH-1:0] wmask1,
    input  logic [DATA_WIDTH-1:0]  dout0,
    input  logic [DATA_WIDTH-1:0]  dout1,
`ifdef GPIO_SCAN_PARITY_EN
    output logic                   scan_parity,
    output logic                   parity_err,
`endif
    output logic                   busy
);
    localparam int PORT_W  = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
    localparam int DIN_OFS = WMASK_WIDTH + 2;
    localparam int SEL_LSB = 2 * PORT_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [CHAIN_WIDTH-1:0] chain_q, chain_d;
    logic [1:0]             state_q, state_d;
    logic                   gcsb_q, gcsb_prev_q;
    logic                   pending_load_q, pending_load_d;
    logic [SEL_WIDTH-1:0]   sel_q;

    logic                   csb_q   [2];
    logic                   web_q   [2];
    logic                   rd_q    [2];
    logic [ADDR_WIDTH-1:0]  addr_q  [2];
    logic [DATA_WIDTH-1:0]  din_q   [2];
    logic [WMASK_WIDTH-1:0] wmask_q [2];
    logic [DATA_WIDTH-1:0]  cap_q   [2];

    logic                   f_csb   [2];
    logic                   f_web   [2];
    logic [ADDR_WIDTH-1:0]  f_addr  [2];
    logic [DATA_WIDTH-1:0]  f_din   [2];
    logic [WMASK_WIDTH-1:0] f_wmask [2];
    logic [DATA_WIDTH-1:0]  dout_w  [2];

    logic strobe_fall, parity_ok, launch, do_load;

    // Port 0 sits above port 1 in the chain; both share the same field order.
    for (genvar gi = 0; gi < 2; gi++) begin : g_field
        localparam int BASE = (1 - gi) * PORT_W;
        assign f_wmask[gi] = chain_q[BASE +: WMASK_WIDTH];
        assign f_web[gi]   = chain_q[BASE + WMASK_WIDTH];
        assign f_csb[gi]   = chain_q[BASE + WMASK_WIDTH + 1];
        assign f_din[gi]   = chain_q[BASE + DIN_OFS +: DATA_WIDTH];
        assign f_addr[gi]  = chain_q[BASE + DIN_OFS + DATA_WIDTH +: ADDR_WIDTH];
    end

    assign dout_w[0] = dout0;
    assign dout_w[1] = dout1;

    // global_csb is registered once before edge detection, which sets the N+1 / N+3 access latency.
    assign strobe_fall = (state_q == IDLE) && !gcsb_q && gcsb_prev_q && !scan_en;
    assign launch      = strobe_fall && parity_ok;
    assign do_load     = (state_q == IDLE) && !scan_en && (sram_load || pending_load_q);

`ifdef GPIO_SCAN_PARITY_EN
    logic parity_q, parity_err_q;
    assign parity_ok   = !parity_q;
    assign scan_parity = parity_q;
    assign parity_err  = parity_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (strobe_fall) begin
                parity_q <= 1'b0;
                if (parity_q) parity_err_q <= 1'b1;
            end else if (scan_en) begin
                parity_q <= parity_q ^ scan_in;
            end
        end
    end
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        chain_d        = chain_q;
        pending_load_d = pending_load_q;
        state_d        = state_q;
        if (scan_en) begin
            chain_d = {chain_q[CHAIN_WIDTH-2:0], scan_in};
        end else if (do_load) begin
            chain_d[PORT_W + DIN_OFS +: DATA_WIDTH] = cap_q[0];
            chain_d[DIN_OFS +: DATA_WIDTH]          = cap_q[1];
        end
        if (do_load)                               pending_load_d = 1'b0;
        else if (sram_load && (state_q != IDLE))   pending_load_d = 1'b1;
        case (state_q)
            IDLE:    if (launch) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q        <= '0;
            state_q        <= IDLE;
            gcsb_q         <= 1'b1;
            gcsb_prev_q    <= 1'b1;
            pending_load_q <= 1'b0;
            sel_q          <= '0;
            for (int i = 0; i < 2; i++) begin
                csb_q[i]   <= 1'b1;
                web_q[i]   <= 1'b1;
                rd_q[i]    <= 1'b0;
                addr_q[i]  <= '0;
                din_q[i]   <= '0;
                wmask_q[i] <= '0;
                cap_q[i]   <= '0;
            end
        end else begin
            chain_q        <= chain_d;
            state_q        <= state_d;
            gcsb_q         <= global_csb;
            gcsb_prev_q    <= gcsb_q;
            pending_load_q <= pending_load_d;
            if (launch) sel_q <= chain_q[SEL_LSB +: SEL_WIDTH];
            for (int i = 0; i < 2; i++) begin
                if (launch) begin
                    csb_q[i]   <= f_csb[i];
                    web_q[i]   <= f_web[i];
                    addr_q[i]  <= f_addr[i];
                    din_q[i]   <= f_din[i];
                    wmask_q[i] <= f_wmask[i];
                    rd_q[i]    <= !f_csb[i] && f_web[i];
                end else if (state_q == ACCESS) begin
                    csb_q[i] <= 1'b1;
                end
                if ((state_q == CAPTURE) && rd_q[i]) cap_q[i] <= dout_w[i];
            end
        end
    end

    assign scan_out = chain_q[CHAIN_WIDTH-1];
    assign busy     = (state_q != IDLE);
    assign sram_sel = sel_q;
    assign csb0     = csb_q[0];
    assign web0     = web_q[0];
    assign addr0    = addr_q[0];
    assign din0     = din_q[0];
    assign wmask0   = wmask_q[0];
    assign csb1     = csb_q[1];
    assign web1     = web_q[1];
    assign addr1    = addr_q[1];
    assign din1     = din_q[1];
    assign wmask1   = wmask_q[1];
endmodule
